// File: rtl/decimation_peak_counter.sv
// Decimating capture strobe generator: one sample per window in sample mode,
// per-channel min/max word pair per window in peak-detect mode.
module decimation_peak_counter #(
    parameter int CNT_W  = 24,
    parameter int DATA_W = 8,
    parameter int CH     = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start_WR,
    input  logic                 Mode,
    input  logic [CNT_W-1:0]     Decimation_IN,
    input  logic [CH*DATA_W-1:0] DATA_IN,
    output logic                 EN,
    output logic                 CLK_EN,
    output logic                 Min_Max_Sel,
    output logic [CH*DATA_W-1:0] DATA_OUT,
    output logic                 Busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]           state;
    logic                 str_wr;
    logic                 mode_l;
    logic                 first;
    logic                 max_pend;
    logic [CNT_W-1:0]     d_eff;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     d_new;
    logic [CH*DATA_W-1:0] min_c;
    logic [CH*DATA_W-1:0] max_c;
    logic [CH*DATA_W-1:0] max_hold;
    logic [CH*DATA_W-1:0] min_n;
    logic [CH*DATA_W-1:0] max_n;

    // Peak windows need at least two samples so a close never lands on the max word.
    always_comb begin
        d_new = Decimation_IN;
        if (Mode && (Decimation_IN == '0))
            d_new = CNT_W'(1);
    end

    // Running extrema including the current sample; a fresh window restarts from it.
    always_comb begin
        min_n = DATA_IN;
        max_n = DATA_IN;
        for (int unsigned c = 0; c < CH; c++) begin
            if (!first) begin
                if (min_c[c*DATA_W +: DATA_W] < DATA_IN[c*DATA_W +: DATA_W])
                    min_n[c*DATA_W +: DATA_W] = min_c[c*DATA_W +: DATA_W];
                if (max_c[c*DATA_W +: DATA_W] > DATA_IN[c*DATA_W +: DATA_W])
                    max_n[c*DATA_W +: DATA_W] = max_c[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            str_wr      <= 1'b0;
            mode_l      <= 1'b0;
            first       <= 1'b0;
            max_pend    <= 1'b0;
            d_eff       <= '0;
            cnt         <= '0;
            min_c       <= '0;
            max_c       <= '0;
            max_hold    <= '0;
            EN          <= 1'b0;
            CLK_EN      <= 1'b0;
            Min_Max_Sel <= 1'b0;
            DATA_OUT    <= '0;
        end else begin
            str_wr <= Start_WR;
            CLK_EN <= EN;
            EN     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (str_wr) begin
                        state    <= S_RUN;
                        mode_l   <= Mode;
                        d_eff    <= d_new;
                        cnt      <= d_new;
                        first    <= 1'b1;
                        max_pend <= 1'b0;
                    end
                end
                default: begin
                    if (!str_wr) begin
                        state       <= S_IDLE;
                        max_pend    <= 1'b0;
                        Min_Max_Sel <= 1'b0;
                    end else begin
                        min_c <= min_n;
                        max_c <= max_n;
                        if (max_pend) begin
                            DATA_OUT    <= max_hold;
                            Min_Max_Sel <= 1'b1;
                            EN          <= 1'b1;
                            max_pend    <= 1'b0;
                        end
                        if (cnt != '0) begin
                            cnt   <= cnt - 1'b1;
                            first <= 1'b0;
                        end else begin
                            cnt   <= d_eff;
                            first <= 1'b1;
                            EN    <= 1'b1;
                            if (mode_l) begin
                                DATA_OUT    <= min_n;
                                Min_Max_Sel <= 1'b0;
                                max_pend    <= 1'b1;
                                max_hold    <= max_n;
                            end else begin
                                DATA_OUT <= DATA_IN;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign Busy = (state == S_RUN);

endmodule

// File: tb/tb_decimation_peak_counter.sv
// Scoreboard bench: expected output words with their edge number are queued per run
// and checked against every EN strobe, along with CLK_EN lag and Busy.
module tb_decimation_peak_counter;

    localparam int CNT_W = 4;
    localparam int DATA_W = 8;
    localparam int CH = 2;

    logic        CLK;
    logic        RST;
    logic        Start_WR;
    logic        Mode;
    logic [3:0]  Decimation_IN;
    logic [15:0] DATA_IN;
    logic        EN;
    logic        CLK_EN;
    logic        Min_Max_Sel;
    logic [15:0] DATA_OUT;
    logic        Busy;

    decimation_peak_counter #(.CNT_W(CNT_W), .DATA_W(DATA_W), .CH(CH)) dut (
        .CLK(CLK), .RST(RST), .Start_WR(Start_WR), .Mode(Mode),
        .Decimation_IN(Decimation_IN), .DATA_IN(DATA_IN), .EN(EN), .CLK_EN(CLK_EN),
        .Min_Max_Sel(Min_Max_Sel), .DATA_OUT(DATA_OUT), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        sel;
    } exp_t;

    typedef struct {
        logic mode;
        int   d;
        int   d_chg;
        int   n;
        int   pat;
    } vec_t;

    exp_t       q[$];
    vec_t       vecs[8];
    logic [7:0] s0[64];
    logic [7:0] s1[64];
    int         total = 0;
    int         bad = 0;
    logic       en_prev = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, cyc);
        end
    endtask

    // Advances past one rising edge and checks outputs at the following falling edge.
    task automatic tick();
        logic r;
        exp_t e;
        r = RST;
        @(negedge CLK);
        total++;
        if (CLK_EN !== (r ? 1'b0 : en_prev)) begin
            bad++;
            $display("FAIL clk_en: got %b expected %b (edge %0d)", CLK_EN, (r ? 1'b0 : en_prev), cyc);
        end
        en_prev = EN;
        if (EN === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_en: data=%h sel=%b at edge %0d", DATA_OUT, Min_Max_Sel, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || DATA_OUT !== e.data || Min_Max_Sel !== e.sel) begin
                    bad++;
                    $display("FAIL word: edge=%0d data=%h sel=%b expected edge=%0d data=%h sel=%b",
                             cyc, DATA_OUT, Min_Max_Sel, e.cyc, e.data, e.sel);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = q.pop_front();
            $display("FAIL missing_en: edge %0d expected data=%h sel=%b", cyc, e.data, e.sel);
        end
    endtask

    task automatic load_pat(input int pat, input int n);
        logic [7:0] sp0[9];
        logic [7:0] sp1[9];
        sp0 = '{8'd5, 8'd9, 8'd1, 8'd7, 8'd50, 8'd60, 8'd70, 8'd80, 8'd33};
        sp1 = '{8'd200, 8'd10, 8'd30, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4, 8'd99};
        for (int j = 0; j < n; j++) begin
            if (pat == 0) begin
                s0[j] = 8'(j);
                s1[j] = 8'(255 - j);
            end else if (pat == 1 && j < 9) begin
                s0[j] = sp0[j];
                s1[j] = sp1[j];
            end else begin
                s0[j] = 8'($urandom);
                s1[j] = 8'($urandom);
            end
        end
    endtask

    // One run: n samples starting at E2, then Start_WR dropped so edge E2+n is the first idle one.
    task automatic run_vec(input vec_t v);
        int c, de, len, last, nx, j;
        logic [7:0] mn0, mx0, mn1, mx1;
        exp_t e;
        load_pat(v.pat, v.n);
        de = (v.mode && v.d == 0) ? 1 : v.d;
        len = de + 1;
        c = cyc;
        for (int w = 0; (w + 1) * len <= v.n; w++) begin
            last = w * len + de;
            if (!v.mode) begin
                e.cyc = c + 3 + last; e.data = {s1[last], s0[last]}; e.sel = 1'b0;
                q.push_back(e);
            end else begin
                mn0 = 8'hFF; mx0 = 8'h00; mn1 = 8'hFF; mx1 = 8'h00;
                for (int k = w * len; k <= last; k++) begin
                    if (s0[k] < mn0) mn0 = s0[k];
                    if (s0[k] > mx0) mx0 = s0[k];
                    if (s1[k] < mn1) mn1 = s1[k];
                    if (s1[k] > mx1) mx1 = s1[k];
                end
                e.cyc = c + 3 + last; e.data = {mn1, mn0}; e.sel = 1'b0;
                q.push_back(e);
                if (last + 1 <= v.n - 1) begin
                    e.cyc = c + 4 + last; e.data = {mx1, mx0}; e.sel = 1'b1;
                    q.push_back(e);
                end
            end
        end
        Mode = v.mode;
        Decimation_IN = 4'(v.d);
        for (int k = 0; k < v.n + de + 8; k++) begin
            nx = cyc + 1;
            j = nx - (c + 3);
            Start_WR = (nx <= c + 1 + v.n);
            DATA_IN = (j >= 0 && j < v.n) ? {s1[j], s0[j]} : 16'($urandom);
            if (j == 2) begin
                Mode = ~v.mode;
                if (v.d_chg >= 0) Decimation_IN = 4'(v.d_chg);
            end
            tick();
            if (cyc == c + 2) chk("busy_run", int'(Busy), 1);
        end
        chk("busy_idle", int'(Busy), 0);
        chk("queue_drain", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int c;
        exp_t e;
        vecs[0] = '{mode: 1'b0, d: 0,  d_chg: -1, n: 6,  pat: 0};
        vecs[1] = '{mode: 1'b0, d: 3,  d_chg: -1, n: 12, pat: 0};
        vecs[2] = '{mode: 1'b1, d: 3,  d_chg: -1, n: 9,  pat: 1};
        vecs[3] = '{mode: 1'b1, d: 0,  d_chg: -1, n: 8,  pat: 2};
        vecs[4] = '{mode: 1'b0, d: 3,  d_chg: 7,  n: 12, pat: 0};
        vecs[5] = '{mode: 1'b0, d: 7,  d_chg: -1, n: 16, pat: 0};
        vecs[6] = '{mode: 1'b0, d: 15, d_chg: -1, n: 48, pat: 0};
        vecs[7] = '{mode: 1'b1, d: 2,  d_chg: -1, n: 10, pat: 2};

        RST = 1'b1; Start_WR = 1'b0; Mode = 1'b0; Decimation_IN = '0; DATA_IN = '0;
        tick();
        chk("rst_en", int'(EN), 0);
        chk("rst_clk_en", int'(CLK_EN), 0);
        chk("rst_sel", int'(Min_Max_Sel), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_data", int'(DATA_OUT), 0);
        tick();
        RST = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset lands on the edge that would have produced the max word.
        load_pat(1, 9);
        c = cyc;
        e.cyc = c + 6; e.data = {8'd10, 8'd1}; e.sel = 1'b0;
        q.push_back(e);
        Mode = 1'b1;
        Decimation_IN = 4'd3;
        Start_WR = 1'b1;
        for (int k = 0; k < 6; k++) begin
            DATA_IN = (cyc + 1 - (c + 3) >= 0) ? {s1[cyc + 1 - (c + 3)], s0[cyc + 1 - (c + 3)]} : 16'h0;
            tick();
        end
        RST = 1'b1;
        Start_WR = 1'b0;
        tick();
        chk("mid_rst_en", int'(EN), 0);
        chk("mid_rst_clk_en", int'(CLK_EN), 0);
        chk("mid_rst_sel", int'(Min_Max_Sel), 0);
        chk("mid_rst_busy", int'(Busy), 0);
        chk("mid_rst_data", int'(DATA_OUT), 0);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
